// File: rtl/hazard_fwd_unit_if.sv
// Hazard/forwarding bus: ID-stage instruction info in, stall and EX forward selects out.
interface hazard_fwd_unit_if #(
   parameter int unsigned RW    = 4,
   parameter int unsigned DEPTH = 3
);
   localparam int unsigned SW = $clog2(DEPTH + 1);

   logic          freeze;
   logic          flush;
   logic          id_valid;
   logic [RW-1:0] id_rs;
   logic [RW-1:0] id_rt;
   logic          id_rs_used;
   logic          id_rt_used;
   logic          id_wr;
   logic [RW-1:0] id_rd;
   logic          id_is_load;
   logic          stall;
   logic [SW-1:0] fwd_rs_sel;
   logic [SW-1:0] fwd_rt_sel;
   logic          ex_valid;
   logic [15:0]   stall_cnt;

   modport master (
      output freeze, flush, id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
             id_wr, id_rd, id_is_load,
      input  stall, fwd_rs_sel, fwd_rt_sel, ex_valid, stall_cnt
   );

   modport slave (
      input  freeze, flush, id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
             id_wr, id_rd, id_is_load,
      output stall, fwd_rs_sel, fwd_rt_sel, ex_valid, stall_cnt
   );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control: a scoreboard of in-flight writers (entry 0 = EX)
// is searched for the youngest producer of each ID source; not-yet-ready producers stall ID,
// ready ones yield a registered forward select for the consumer's EX cycle.
module hazard_fwd_unit #(
   parameter int unsigned RW       = 4,
   parameter int unsigned DEPTH    = 3,
   parameter int unsigned LOAD_RDY = 2,
   parameter int unsigned ALU_RDY  = 1
) (
   input logic              clk,
   input logic              rst,
   hazard_fwd_unit_if.slave bus
);
   localparam int unsigned SW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] ld_q;
   logic [RW-1:0]    rd_q [DEPTH];
   logic [SW-1:0]    fwd_rs_sel_q;
   logic [SW-1:0]    fwd_rt_sel_q;
   logic             ex_valid_q;
   logic [15:0]      stall_cnt_q;

   logic [RW-1:0]    src [2];
   logic [1:0]       src_used;
   logic [1:0]       hazard;
   logic [SW-1:0]    sel_d [2];
   logic             stall;
   logic             bubble;
   logic             ins_v;

   assign src[0]   = bus.id_rs;
   assign src[1]   = bus.id_rt;
   assign src_used = {bus.id_rt_used, bus.id_rs_used};

   // Youngest matching producer per source; descending scan so the lowest entry wins
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         hazard[s] = 1'b0;
         sel_d[s]  = '0;
         for (int j = int'(DEPTH) - 1; j >= 0; j--) begin
            if (src_used[s] && (src[s] != '0) && v_q[j] && (rd_q[j] == src[s])) begin
               // Producer reaches entry j+1 when the consumer reaches EX
               hazard[s] = (j + 1) < (ld_q[j] ? int'(LOAD_RDY) : int'(ALU_RDY));
               sel_d[s]  = ((j + 1) <= (int'(DEPTH) - 1)) ? SW'(j + 1) : '0;
            end
         end
      end
   end

   assign stall  = bus.id_valid & ~bus.flush & ~bus.freeze & (|hazard);
   assign bubble = stall | bus.flush | ~bus.id_valid;
   assign ins_v  = bus.id_wr & (bus.id_rd != '0);

   // Scoreboard advance, forward selects and stall counter; reset beats freeze
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q          <= '0;
         ld_q         <= '0;
         for (int j = 0; j < int'(DEPTH); j++) rd_q[j] <= '0;
         fwd_rs_sel_q <= '0;
         fwd_rt_sel_q <= '0;
         ex_valid_q   <= 1'b0;
         stall_cnt_q  <= '0;
      end else if (!bus.freeze) begin
         v_q  <= {v_q[DEPTH-2:0], ins_v & ~bubble};
         ld_q <= {ld_q[DEPTH-2:0], bus.id_is_load};
         for (int j = int'(DEPTH) - 1; j > 0; j--) rd_q[j] <= rd_q[j-1];
         rd_q[0]      <= bus.id_rd;
         fwd_rs_sel_q <= bubble ? '0 : sel_d[0];
         fwd_rt_sel_q <= bubble ? '0 : sel_d[1];
         ex_valid_q   <= ~bubble;
         if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign bus.stall      = stall;
   assign bus.fwd_rs_sel = fwd_rs_sel_q;
   assign bus.fwd_rt_sel = fwd_rt_sel_q;
   assign bus.ex_valid   = ex_valid_q;
   assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: default and DEPTH=5/LOAD_RDY=3 instances share one stimulus
// stream, each tracked by an in-flight instruction queue model; directed scenarios plus random.
module tb_hazard_fwd_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, freeze, flush, id_valid, id_wr, id_is_load, rs_used, rt_used;
   logic [3:0] rs, rt, rd;

   hazard_fwd_unit_if #(.RW(4), .DEPTH(3)) bus_a ();
   hazard_fwd_unit_if #(.RW(4), .DEPTH(5)) bus_b ();

   assign bus_a.freeze = freeze;      assign bus_b.freeze = freeze;
   assign bus_a.flush = flush;        assign bus_b.flush = flush;
   assign bus_a.id_valid = id_valid;  assign bus_b.id_valid = id_valid;
   assign bus_a.id_rs = rs;           assign bus_b.id_rs = rs;
   assign bus_a.id_rt = rt;           assign bus_b.id_rt = rt;
   assign bus_a.id_rs_used = rs_used; assign bus_b.id_rs_used = rs_used;
   assign bus_a.id_rt_used = rt_used; assign bus_b.id_rt_used = rt_used;
   assign bus_a.id_wr = id_wr;        assign bus_b.id_wr = id_wr;
   assign bus_a.id_rd = rd;           assign bus_b.id_rd = rd;
   assign bus_a.id_is_load = id_is_load;
   assign bus_b.id_is_load = id_is_load;

   hazard_fwd_unit #(.RW(4), .DEPTH(3), .LOAD_RDY(2), .ALU_RDY(1)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );
   hazard_fwd_unit #(.RW(4), .DEPTH(5), .LOAD_RDY(3), .ALU_RDY(1)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

   typedef struct packed {
      logic       v;
      logic [3:0] rd;
      logic       ld;
   } ent_t;

   // In-flight instructions, youngest (EX) first
   ent_t        qa[$];
   ent_t        qb[$];
   int          m_rs[2];
   int          m_rt[2];
   logic        m_exv[2];
   logic [15:0] m_cnt[2];
   int          n_checks = 0;
   int          n_err = 0;
   logic        obs_stall_a, obs_stall_b;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int depth(input int d);
      return (d == 0) ? 3 : 5;
   endfunction

   function automatic int load_rdy(input int d);
      return (d == 0) ? 2 : 3;
   endfunction

   function automatic ent_t entry(input int d, input int j);
      if (d == 0) return qa[j];
      return qb[j];
   endfunction

   task automatic lookup(input int d, input logic [3:0] src, input logic used,
                         output logic hz, output int sel);
      hz  = 1'b0;
      sel = 0;
      if (used && (src != 4'd0)) begin
         for (int j = 0; j < depth(d); j++) begin
            ent_t e;
            e = entry(d, j);
            if (e.v && (e.rd == src)) begin
               hz  = (j + 1) < (e.ld ? load_rdy(d) : 1);
               sel = ((j + 1) <= depth(d) - 1) ? j + 1 : 0;
               break;
            end
         end
      end
   endtask

   task automatic model_clear();
      qa.delete();
      qb.delete();
      repeat (3) qa.push_back('0);
      repeat (5) qb.push_back('0);
      for (int d = 0; d < 2; d++) begin
         m_rs[d] = 0; m_rt[d] = 0; m_exv[d] = 1'b0; m_cnt[d] = 16'd0;
      end
   endtask

   // One clock: check comb stall, advance models at the edge, check registered outputs
   task automatic cycle();
      logic hz1, hz2;
      int   s1[2];
      int   s2[2];
      logic st[2];
      for (int d = 0; d < 2; d++) begin
         lookup(d, rs, rs_used, hz1, s1[d]);
         lookup(d, rt, rt_used, hz2, s2[d]);
         st[d] = id_valid & ~flush & ~freeze & (hz1 | hz2);
      end
      #1;
      obs_stall_a = bus_a.stall;
      obs_stall_b = bus_b.stall;
      check("stall_a", 32'(obs_stall_a), 32'(st[0]));
      check("stall_b", 32'(obs_stall_b), 32'(st[1]));
      @(posedge clk);
      if (rst) begin
         model_clear();
      end else if (!freeze) begin
         for (int d = 0; d < 2; d++) begin
            logic bub;
            ent_t ne;
            bub   = st[d] | flush | ~id_valid;
            ne.v  = ~bub & id_wr & (rd != 4'd0);
            ne.rd = rd;
            ne.ld = id_is_load;
            if (d == 0) begin qa.push_front(ne); void'(qa.pop_back()); end
            else begin qb.push_front(ne); void'(qb.pop_back()); end
            m_rs[d]  = bub ? 0 : s1[d];
            m_rt[d]  = bub ? 0 : s2[d];
            m_exv[d] = ~bub;
            if (st[d] && (m_cnt[d] != 16'hFFFF)) m_cnt[d] = m_cnt[d] + 16'd1;
         end
      end
      #1;
      check("rs_sel_a", 32'(bus_a.fwd_rs_sel), m_rs[0]);
      check("rt_sel_a", 32'(bus_a.fwd_rt_sel), m_rt[0]);
      check("ex_valid_a", 32'(bus_a.ex_valid), 32'(m_exv[0]));
      check("stall_cnt_a", 32'(bus_a.stall_cnt), 32'(m_cnt[0]));
      check("rs_sel_b", 32'(bus_b.fwd_rs_sel), m_rs[1]);
      check("rt_sel_b", 32'(bus_b.fwd_rt_sel), m_rt[1]);
      check("ex_valid_b", 32'(bus_b.ex_valid), 32'(m_exv[1]));
      check("stall_cnt_b", 32'(bus_b.stall_cnt), 32'(m_cnt[1]));
   endtask

   task automatic idle();
      id_valid = 1'b0; id_wr = 1'b0; id_is_load = 1'b0; rs_used = 1'b0; rt_used = 1'b0;
      rs = 4'd0; rt = 4'd0; rd = 4'd0; flush = 1'b0; freeze = 1'b0;
   endtask

   task automatic alu(input logic [3:0] d_, input logic [3:0] s_, input logic [3:0] t_);
      id_valid = 1'b1; id_wr = 1'b1; id_is_load = 1'b0;
      rd = d_; rs = s_; rt = t_; rs_used = 1'b1; rt_used = 1'b1;
   endtask

   task automatic lw(input logic [3:0] d_, input logic [3:0] b_);
      id_valid = 1'b1; id_wr = 1'b1; id_is_load = 1'b1;
      rd = d_; rs = b_; rt = 4'd0; rs_used = 1'b1; rt_used = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      model_clear();
      idle();
      rst = 1'b1;
      @(negedge clk);
      do_reset();
      check("rst_rs_sel", 32'(bus_a.fwd_rs_sel), 32'd0);
      check("rst_ex_valid", 32'(bus_a.ex_valid), 32'd0);
      check("rst_stall_cnt", 32'(bus_a.stall_cnt), 32'd0);
      cycle();
      check("rst_stall", 32'(obs_stall_a), 32'd0);

      // ALU -> ALU chain forwards from MEM without stalling
      do_reset();
      alu(4'd3, 4'd1, 4'd2); cycle();
      alu(4'd4, 4'd3, 4'd5); cycle();
      check("alu_chain_stall", 32'(obs_stall_a), 32'd0);
      check("alu_chain_rs_sel", 32'(bus_a.fwd_rs_sel), 32'd1);
      check("alu_chain_rt_sel", 32'(bus_a.fwd_rt_sel), 32'd0);

      // Load-use: one stall, then both sources forward from WB
      do_reset();
      lw(4'd2, 4'd7); cycle();
      alu(4'd6, 4'd2, 4'd2);
      n = 0;
      for (int k = 0; k < 6; k++) begin
         cycle();
         if (obs_stall_a) n++;
         else break;
      end
      check("ld_use_stalls", 32'(n), 32'd1);
      check("ld_use_rs_sel", 32'(bus_a.fwd_rs_sel), 32'd2);
      check("ld_use_rt_sel", 32'(bus_a.fwd_rt_sel), 32'd2);
      check("ld_use_cnt", 32'(bus_a.stall_cnt), 32'd1);

      // Youngest producer wins, R0 source never forwards
      do_reset();
      alu(4'd1, 4'd2, 4'd3); cycle();
      alu(4'd1, 4'd4, 4'd5); cycle();
      alu(4'd7, 4'd1, 4'd0); cycle();
      check("young_stall", 32'(obs_stall_a), 32'd0);
      check("young_rs_sel", 32'(bus_a.fwd_rs_sel), 32'd1);
      check("young_r0_sel", 32'(bus_a.fwd_rt_sel), 32'd0);
      do_reset();
      lw(4'd0, 4'd1); cycle();
      alu(4'd5, 4'd0, 4'd0); cycle();
      check("rd0_stall", 32'(obs_stall_a), 32'd0);

      // Flush beats stall
      do_reset();
      lw(4'd2, 4'd7); cycle();
      alu(4'd6, 4'd2, 4'd2); flush = 1'b1; cycle();
      check("flush_stall", 32'(obs_stall_a), 32'd0);
      check("flush_ex_valid", 32'(bus_a.ex_valid), 32'd0);
      flush = 1'b0;

      // Freeze holds everything, stall resumes afterwards
      do_reset();
      lw(4'd2, 4'd7); cycle();
      alu(4'd6, 4'd2, 4'd2); freeze = 1'b1;
      repeat (3) begin
         cycle();
         check("freeze_stall", 32'(obs_stall_a), 32'd0);
      end
      check("freeze_cnt", 32'(bus_a.stall_cnt), 32'd0);
      check("freeze_ex_valid", 32'(bus_a.ex_valid), 32'd1);
      freeze = 1'b0;
      cycle();
      check("thaw_stall", 32'(obs_stall_a), 32'd1);
      cycle();
      check("thaw_issue", 32'(obs_stall_a), 32'd0);
      check("thaw_cnt", 32'(bus_a.stall_cnt), 32'd1);

      // DEPTH=5, LOAD_RDY=3: two stalls then forward from entry 3
      do_reset();
      lw(4'd2, 4'd7); cycle();
      alu(4'd6, 4'd2, 4'd2);
      n = 0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         if (obs_stall_b) n++;
         else break;
      end
      check("sweep_stalls", 32'(n), 32'd2);
      check("sweep_rs_sel", 32'(bus_b.fwd_rs_sel), 32'd3);
      do_reset();
      alu(4'd3, 4'd1, 4'd1); cycle();
      idle(); repeat (4) cycle();
      alu(4'd4, 4'd3, 4'd3); cycle();
      check("sweep_old_sel", 32'(bus_b.fwd_rs_sel), 32'd0);
      check("sweep_old_exv", 32'(bus_b.ex_valid), 32'd1);

      // Reset in the middle of a stall empties the scoreboard
      do_reset();
      lw(4'd2, 4'd7); cycle();
      alu(4'd6, 4'd2, 4'd2); rst = 1'b1; cycle();
      check("rst_mid_stall_before", 32'(obs_stall_a), 32'd1);
      rst = 1'b0;
      check("rst_mid_rs_sel", 32'(bus_a.fwd_rs_sel), 32'd0);
      check("rst_mid_ex_valid", 32'(bus_a.ex_valid), 32'd0);
      check("rst_mid_cnt", 32'(bus_a.stall_cnt), 32'd0);
      cycle();
      check("rst_mid_stall_after", 32'(obs_stall_a), 32'd0);

      // Counter saturation from a preloaded 16'hFFFE across three stall cycles
      do_reset();
      force dut_a.stall_cnt_q = 16'hFFFE;
      m_cnt[0] = 16'hFFFE;
      #1;
      release dut_a.stall_cnt_q;
      repeat (3) begin
         lw(4'd2, 4'd7); cycle();
         alu(4'd6, 4'd2, 4'd2); cycle(); cycle();
      end
      check("sat_cnt", 32'(bus_a.stall_cnt), 32'hFFFF);

      // Random traffic against the queue model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst        = ($urandom_range(0, 59) == 0);
         freeze     = ($urandom_range(0, 7) == 0);
         flush      = ($urandom_range(0, 9) == 0);
         id_valid   = ($urandom_range(0, 3) != 0);
         id_wr      = ($urandom_range(0, 3) != 0);
         id_is_load = ($urandom_range(0, 2) == 0);
         rs_used    = ($urandom_range(0, 3) != 0);
         rt_used    = ($urandom_range(0, 1) != 0);
         rs         = 4'($urandom_range(0, 7));
         rt         = 4'($urandom_range(0, 7));
         rd         = 4'($urandom_range(0, 7));
         cycle();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
